// File: rtl/core_sequencer.sv
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle instruction sequencer. Walks each instruction
//               through IDLE -> FETCH -> DECODE -> EXECUTE -> [MEM] -> WB.
//               It handles branches, loads and stores, halt and illegal ops,
//               and bounded memory waits. Optional performance counters are
//               built only when the macro CORE_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        in   1       clock, rising edge
//   reset_i      in   1       asynchronous active-low reset
//   run_i        in   1       permission to start the next instruction
//   imem_req_o   out  1       instruction fetch request (FETCH)
//   imem_ack_i   in   1       fetch complete, instr_i valid
//   instr_i      in   XLEN    fetched instruction
//   pc_o         out  ADDR_W  program counter
//   ir_o         out  XLEN    instruction register
//   exe_en_o     out  1       execute enable, one pulse per instruction
//   mem_op_i     in   2       00 none, 01 load, 10 store, 11 illegal
//   br_taken_i   in   1       branch taken (sampled in EXECUTE)
//   br_target_i  in   ADDR_W  branch target (sampled in EXECUTE)
//   halt_i       in   1       ecall/ebreak (sampled in EXECUTE)
//   dmem_req_o   out  1       data memory request (MEM)
//   dmem_wr_o    out  1       data memory write qualifier (MEM, store)
//   dmem_ack_i   in   1       data access complete
//   rf_we_o      out  1       register-file write enable (WB, non-store)
//   state_o      out  3       current state code
//   halted_o     out  1       sticky halt
//   err_o        out  1       sticky error
//   cycle_o      out  32      active-cycle counter (0 when counters absent)
//   instret_o    out  32      retired-instruction counter (0 when absent)
// Configuration macro: CORE_PERF_CNT_EN
// ============================================================================
`default_nettype none

module core_sequencer #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              run_i,
    output logic              imem_req_o,
    input  logic              imem_ack_i,
    input  logic [XLEN-1:0]   instr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [XLEN-1:0]   ir_o,
    output logic              exe_en_o,
    input  logic [1:0]        mem_op_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              halt_i,
    output logic              dmem_req_o,
    output logic              dmem_wr_o,
    input  logic              dmem_ack_i,
    output logic              rf_we_o,
    output logic [2:0]        state_o,
    output logic              halted_o,
    output logic              err_o,
    output logic [31:0]       cycle_o,
    output logic [31:0]       instret_o
);

    // Wait counter only needs to reach TIMEOUT-1: the last waiting cycle
    // decides the timeout instead of incrementing.
    localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(RESET_PC);

    localparam logic [1:0] MOP_NONE  = 2'b00;
    localparam logic [1:0] MOP_STORE = 2'b10;
    localparam logic [1:0] MOP_ILL   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]     ir_q, ir_d;
    logic [1:0]          mem_op_q, mem_op_d;
    logic                br_taken_q, br_taken_d;
    logic [ADDR_W-1:0]   br_target_q, br_target_d;
    logic                err_q, err_d;
    logic                store_d;

    logic                imem_req_q;
    logic                exe_en_q;
    logic                dmem_req_q;
    logic                dmem_wr_q;
    logic                rf_we_q;
    logic                halted_q;

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        pc_d        = pc_q;
        ir_d        = ir_q;
        mem_op_d    = mem_op_q;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    ir_d    = instr_i;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                mem_op_d    = mem_op_i;
                br_taken_d  = br_taken_i;
                br_target_d = br_target_i;
                if (halt_i) begin
                    state_d = S_HALT;
                end else if (mem_op_i == MOP_ILL) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else if (mem_op_i != MOP_NONE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack_i) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                // Natural ADDR_W-bit wrap of the sequential increment.
                pc_d    = br_taken_q ? br_target_q : (pc_q + ADDR_W'(4));
                state_d = run_i ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign store_d = (mem_op_d == MOP_STORE);

    // Strobes are decoded from the next state so that every output comes
    // straight from a flop and lines up with state_o.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            pc_q        <= PC_RST;
            ir_q        <= '0;
            mem_op_q    <= MOP_NONE;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            err_q       <= 1'b0;
            imem_req_q  <= 1'b0;
            exe_en_q    <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_wr_q   <= 1'b0;
            rf_we_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mem_op_q    <= mem_op_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            err_q       <= err_d;
            imem_req_q  <= (state_d == S_FETCH);
            exe_en_q    <= (state_d == S_EXECUTE);
            dmem_req_q  <= (state_d == S_MEM);
            dmem_wr_q   <= (state_d == S_MEM) && store_d;
            rf_we_q     <= (state_d == S_WB) && !store_d;
            halted_q    <= (state_d == S_HALT);
        end
    end

    assign imem_req_o = imem_req_q;
    assign exe_en_o   = exe_en_q;
    assign dmem_req_o = dmem_req_q;
    assign dmem_wr_o  = dmem_wr_q;
    assign rf_we_o    = rf_we_q;
    assign halted_o   = halted_q;
    assign err_o      = err_q;
    assign pc_o       = pc_q;
    assign ir_o       = ir_q;
    assign state_o    = state_q;

`ifdef CORE_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (state_q != S_HALT)) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (state_q == S_WB) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign cycle_o   = cycle_q;
    assign instret_o = instret_q;
`else
    assign cycle_o   = '0;
    assign instret_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction width.
REQ-002 SHALL have parameter ADDR_W, default 12, byte-address width of pc_o and br_target_i.
REQ-003 SHALL have parameter RESET_PC, default 0, pc_o value after reset.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for a memory acknowledge.
REQ-005 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port run_i  input  1  permission to start the next instruction.
REQ-008 SHALL have port imem_req_o  output  1  instruction fetch request.
REQ-009 SHALL have port imem_ack_i  input  1  fetch complete; instr_i valid.
REQ-010 SHALL have port instr_i  input  XLEN  fetched instruction.
REQ-011 SHALL have port pc_o  output  ADDR_W  current program counter.
REQ-012 SHALL have port ir_o  output  XLEN  latched instruction register.
REQ-013 SHALL have port exe_en_o  output  1  execute-stage enable, one pulse per instruction.
REQ-014 SHALL have port mem_op_i  input  2  from decode: 00 none, 01 load, 10 store, 11 illegal.
REQ-015 SHALL have port br_taken_i  input  1  branch/jump taken, valid in EXECUTE.
REQ-016 SHALL have port br_target_i  input  ADDR_W  branch target, valid in EXECUTE.
REQ-017 SHALL have port halt_i  input  1  ecall/ebreak decoded, valid in EXECUTE.
REQ-018 SHALL have port dmem_req_o  output  1  data memory request.
REQ-019 SHALL have port dmem_wr_o  output  1  data memory write qualifier.
REQ-020 SHALL have port dmem_ack_i  input  1  data access complete.
REQ-021 SHALL have port rf_we_o  output  1  register-file write enable, one pulse.
REQ-022 SHALL have ports state_o  output  3  current state code; halted_o  output  1  sticky halt; err_o  output  1  sticky error.
REQ-023 SHALL have ports cycle_o and instret_o, each output 32, performance counters.

Function
REQ-024 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6; state_o shows the code.
REQ-025 IDLE: -> FETCH when run_i=1; otherwise hold.
REQ-026 FETCH: imem_req_o=1 while in state; on imem_ack_i=1, ir_o<=instr_i -> DECODE; an ack in the first FETCH cycle is legal.
REQ-027 DECODE: exactly one cycle -> EXECUTE.
REQ-028 EXECUTE: exe_en_o=1 for one cycle; sample br_taken_i/br_target_i internally; priority halt_i -> HALT, then mem_op_i=11 -> err_o=1, HALT, then 01/10 -> MEM, else -> WB.
REQ-029 MEM: dmem_req_o=1, dmem_wr_o=1 iff store; on dmem_ack_i=1 -> WB.
REQ-030 WB: rf_we_o=1 unless the instruction is a store; pc_o<=sampled target if taken, else pc_o+4, modulo 2^ADDR_W; instret increments; -> FETCH if run_i=1, else IDLE.
REQ-031 Wait counter SHALL clear on entry to FETCH/MEM and increment each cycle without ack; reaching TIMEOUT without ack -> err_o=1, HALT, request dropped.
REQ-032 run_i=0 mid-instruction SHALL NOT abort; the instruction completes through WB, then IDLE.
REQ-033 HALT: all request/enable outputs 0, halted_o=1; exit only by reset; halting instructions are not counted in instret.
REQ-034 All outputs except pc_o, ir_o, state_o and the counters SHALL be 0 outside their named states.

Reset
REQ-035 reset_i=0 SHALL immediately force IDLE, pc_o=RESET_PC, ir_o=0, all flags, counters and strobes 0, including mid-access.
REQ-036 After reset release the first FETCH SHALL occur no earlier than the cycle after run_i is sampled 1.

Configuration
REQ-037 With macro CORE_PERF_CNT_EN defined: cycle_o counts every cycle not in IDLE or HALT, instret_o counts WB cycles; both wrap modulo 2^32.
REQ-038 Without CORE_PERF_CNT_EN: cycle_o and instret_o SHALL be constant 0 and no counter flops are built.

Verification
REQ-039 ALU op, run_i=1, imem ack after 2 cycles -> FETCH(3 cycles), DECODE, EXECUTE, WB; pc_o 0x000->0x004, rf_we_o one pulse.
REQ-040 Taken branch, target 0x100, in EXECUTE -> pc_o=0x100 after WB; untaken -> pc_o+4.
REQ-041 Store with dmem ack after 1 cycle -> dmem_req_o=1, dmem_wr_o=1 for 2 cycles, rf_we_o stays 0.
REQ-042 imem_ack_i held 0 with TIMEOUT=15 -> err_o=1, halted_o=1, state_o=6 after 15 wait cycles.
REQ-043 halt_i=1 with mem_op_i=01 in EXECUTE -> HALT, no dmem_req_o, instret_o unchanged; reset_i=0 -> IDLE, pc_o=RESET_PC.
REQ-044 pc_o=0xFFC (ADDR_W=12), sequential instruction -> pc_o=0x000; with CORE_PERF_CNT_EN, instret_o=1 after the first instruction.
